// File: rtl/msi_dir_pkg.sv
// Shared types and constants for the three-processor MSI home directory:
// block/op encodings, controller states, directory entry layout and helpers.
package msi_dir_pkg;

    localparam int DIR_NUM_BLOCKS = 8;
    localparam int DIR_NUM_PROC   = 3;

    localparam logic [3:0] ADDR_MIN = 4'd1;
    localparam logic [3:0] ADDR_MAX = 4'd8;

    typedef enum logic [1:0] {
        BLK_U = 2'b00,
        BLK_S = 2'b01,
        BLK_M = 2'b10
    } blk_state_e;

    typedef enum logic [1:0] {
        OP_READ_MISS  = 2'b00,
        OP_WRITE_MISS = 2'b01,
        OP_WRITE_BACK = 2'b10,
        OP_RSVD       = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_INVAL,
        ST_FETCH,
        ST_MEMRD,
        ST_MEMWR,
        ST_RESPOND
    } dir_state_e;

    typedef struct packed {
        blk_state_e                state;
        logic [DIR_NUM_PROC-1:0]   sharers;
        logic [1:0]                owner;
    } dir_entry_t;

    // One-hot sharer bit for a processor id; id 3 shifts out to zero.
    function automatic logic [DIR_NUM_PROC-1:0] procBit(input logic [1:0] p);
        return {{(DIR_NUM_PROC-1){1'b0}}, 1'b1} << p;
    endfunction

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/msi_dir_table.sv
// Directory entry storage: one combinational read port, one write port,
// every entry cleared to U / no sharers / owner 0 by ResetN.
module msi_dir_table
    import msi_dir_pkg::*;
#(
    parameter int NUM_BLOCKS = DIR_NUM_BLOCKS
) (
    input  logic                          Clock,
    input  logic                          ResetN,
    input  logic [$clog2(NUM_BLOCKS)-1:0] i_rdIndex,
    output dir_entry_t                    o_rdEntry,
    input  logic                          i_wrEn,
    input  logic [$clog2(NUM_BLOCKS)-1:0] i_wrIndex,
    input  dir_entry_t                    i_wrEntry
);

    dir_entry_t r_entries [NUM_BLOCKS];

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                r_entries[i] <= '0;
            end
        end else if (i_wrEn) begin
            r_entries[i_wrIndex] <= i_wrEntry;
        end
    end

    assign o_rdEntry = r_entries[i_rdIndex];

endmodule

// File: rtl/msi_directory_controller.sv
// MSI home directory for P0..P2: serialises requests, issues invalidates and
// owner fetches, drives memory. Define DIR_STATS_EN to add saturating counters.
module msi_directory_controller
    import msi_dir_pkg::*;
#(
    parameter int NUM_BLOCKS = DIR_NUM_BLOCKS,
    parameter int NUM_PROC   = DIR_NUM_PROC
) (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic       ReqValid,
    output logic       ReqReady,
    input  logic [1:0] ReqProcessor,
    input  logic [1:0] ReqOp,
    input  logic [3:0] ReqAddress,
    input  logic [3:0] ReqData,
    output logic       InvalValid,
    output logic [2:0] InvalMask,
    output logic       FetchValid,
    output logic [1:0] FetchProcessor,
    input  logic       FetchAck,
    input  logic [3:0] FetchData,
    output logic       MemReqValid,
    output logic       MemWrite,
    output logic [3:0] MemAddress,
    output logic [3:0] MemWrData,
    input  logic       MemRdValid,
    input  logic [3:0] MemRdData,
    output logic       RespValid,
    output logic [1:0] RespProcessor,
    output logic [3:0] RespData,
    output logic       RespError
`ifdef DIR_STATS_EN
    ,
    output logic [7:0] ReadMissCount,
    output logic [7:0] WriteMissCount,
    output logic [7:0] WriteBackCount,
    output logic [7:0] InvalCount
`endif
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);

    dir_state_e       r_state;
    dir_state_e       w_next;
    op_e              r_op;
    logic [1:0]       r_proc;
    logic [3:0]       r_addr;
    logic [3:0]       r_data;
    logic             r_error;
    logic [2:0]       r_invalMask;
    logic             r_reqReady;
    logic             r_invalValid;
    logic             r_fetchValid;
    logic             r_memReqValid;
    logic             r_memWrite;
    logic             r_respValid;

    dir_entry_t       w_entry;
    dir_entry_t       w_newEntry;
    logic [IDX_W-1:0] w_index;
    logic [2:0]       w_reqBit;
    logic [2:0]       w_invalMask;
    logic [3:0]       w_dataIn;
    logic             w_accept;
    logic             w_ownsM;
    logic             w_bad;
    logic             w_wrEn;
    logic             w_setError;
    logic             w_loadData;

    assign w_index  = IDX_W'(r_addr - 4'd1);
    assign w_reqBit = procBit(r_proc);
    assign w_accept = (r_state == ST_IDLE) && r_reqReady && ReqValid;
    assign w_ownsM  = (w_entry.state == BLK_M) && (w_entry.owner == r_proc);
    // A write-back must come from the M owner; a miss from the M owner is a protocol error.
    assign w_bad    = (r_addr < ADDR_MIN) || (r_addr > ADDR_MAX) || (r_op == OP_RSVD) ||
                      (int'(r_proc) >= NUM_PROC) ||
                      ((r_op == OP_WRITE_BACK) ? !w_ownsM : w_ownsM);

    msi_dir_table #(
        .NUM_BLOCKS(NUM_BLOCKS)
    ) u_table (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .i_rdIndex (w_index),
        .o_rdEntry (w_entry),
        .i_wrEn    (w_wrEn),
        .i_wrIndex (w_index),
        .i_wrEntry (w_newEntry)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_setError  = 1'b0;
        w_loadData  = 1'b0;
        w_dataIn    = r_data;
        w_invalMask = '0;
        w_wrEn      = 1'b0;
        w_newEntry  = w_entry;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_bad) begin
                    w_next     = ST_RESPOND;
                    w_setError = 1'b1;
                    w_loadData = 1'b1;
                    w_dataIn   = '0;
                end else begin
                    case (r_op)
                        OP_READ_MISS: begin
                            w_next = (w_entry.state == BLK_M) ? ST_FETCH : ST_MEMRD;
                        end
                        OP_WRITE_MISS: begin
                            if (w_entry.state == BLK_M) begin
                                w_invalMask = procBit(w_entry.owner);
                                w_next      = ST_INVAL;
                            end else if (w_entry.state == BLK_S) begin
                                w_invalMask = w_entry.sharers & ~w_reqBit;
                                w_next      = (w_invalMask != '0) ? ST_INVAL : ST_MEMRD;
                            end else begin
                                w_next = ST_MEMRD;
                            end
                        end
                        default: begin
                            w_next = ST_MEMWR;
                        end
                    endcase
                end
            end
            ST_INVAL: begin
                w_next = (w_entry.state == BLK_M) ? ST_FETCH : ST_MEMRD;
            end
            ST_FETCH: begin
                if (FetchAck) begin
                    w_loadData = 1'b1;
                    w_dataIn   = FetchData;
                    w_next     = (r_op == OP_READ_MISS) ? ST_MEMWR : ST_RESPOND;
                end
            end
            ST_MEMRD: begin
                // The request cycle still has r_memReqValid set; only later data counts.
                if (MemRdValid && !r_memReqValid) begin
                    w_loadData = 1'b1;
                    w_dataIn   = MemRdData;
                    w_next     = ST_RESPOND;
                end
            end
            ST_MEMWR: begin
                w_next = ST_RESPOND;
            end
            ST_RESPOND: begin
                w_next = ST_IDLE;
                if (!r_error) begin
                    w_wrEn = 1'b1;
                    case (r_op)
                        OP_READ_MISS: begin
                            w_newEntry.state   = BLK_S;
                            w_newEntry.sharers = (w_entry.state == BLK_M)
                                               ? (procBit(w_entry.owner) | w_reqBit)
                                               : (w_entry.sharers | w_reqBit);
                        end
                        OP_WRITE_MISS: begin
                            w_newEntry.state   = BLK_M;
                            w_newEntry.owner   = r_proc;
                            w_newEntry.sharers = w_reqBit;
                        end
                        default: begin
                            w_newEntry.state   = BLK_U;
                            w_newEntry.owner   = '0;
                            w_newEntry.sharers = '0;
                        end
                    endcase
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request latch plus registered strobes decoded from the state being entered.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_op          <= OP_READ_MISS;
            r_proc        <= '0;
            r_addr        <= '0;
            r_data        <= '0;
            r_error       <= 1'b0;
            r_invalMask   <= '0;
            r_reqReady    <= 1'b0;
            r_invalValid  <= 1'b0;
            r_fetchValid  <= 1'b0;
            r_memReqValid <= 1'b0;
            r_memWrite    <= 1'b0;
            r_respValid   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= op_e'(ReqOp);
                r_proc  <= ReqProcessor;
                r_addr  <= ReqAddress;
                r_data  <= ReqData;
                r_error <= 1'b0;
            end else begin
                if (w_loadData) begin
                    r_data <= w_dataIn;
                end
                if (w_setError) begin
                    r_error <= 1'b1;
                end
            end
            if (w_next == ST_INVAL) begin
                r_invalMask <= w_invalMask;
            end
            r_reqReady    <= (w_next == ST_IDLE);
            r_invalValid  <= (w_next == ST_INVAL);
            r_fetchValid  <= (w_next == ST_FETCH) && (r_state != ST_FETCH);
            r_memReqValid <= ((w_next == ST_MEMRD) && (r_state != ST_MEMRD)) || (w_next == ST_MEMWR);
            r_memWrite    <= (w_next == ST_MEMWR);
            r_respValid   <= (w_next == ST_RESPOND);
        end
    end

    assign ReqReady       = r_reqReady;
    assign InvalValid     = r_invalValid;
    assign InvalMask      = r_invalValid ? r_invalMask : '0;
    assign FetchValid     = r_fetchValid;
    assign FetchProcessor = r_fetchValid ? w_entry.owner : '0;
    assign MemReqValid    = r_memReqValid;
    assign MemWrite       = r_memWrite;
    assign MemAddress     = r_memReqValid ? r_addr : '0;
    assign MemWrData      = (r_memReqValid && r_memWrite) ? r_data : '0;
    assign RespValid      = r_respValid;
    assign RespProcessor  = r_respValid ? r_proc : '0;
    assign RespData       = r_respValid ? r_data : '0;
    assign RespError      = r_respValid && r_error;

`ifdef DIR_STATS_EN
    logic [7:0] r_readMissCount;
    logic [7:0] r_writeMissCount;
    logic [7:0] r_writeBackCount;
    logic [7:0] r_invalCount;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_readMissCount  <= '0;
            r_writeMissCount <= '0;
            r_writeBackCount <= '0;
            r_invalCount     <= '0;
        end else begin
            if (r_invalValid) begin
                r_invalCount <= satInc(r_invalCount);
            end
            if ((r_state == ST_RESPOND) && !r_error) begin
                case (r_op)
                    OP_READ_MISS:  r_readMissCount  <= satInc(r_readMissCount);
                    OP_WRITE_MISS: r_writeMissCount <= satInc(r_writeMissCount);
                    OP_WRITE_BACK: r_writeBackCount <= satInc(r_writeBackCount);
                    default:       r_writeBackCount <= r_writeBackCount;
                endcase
            end
        end
    end

    assign ReadMissCount  = r_readMissCount;
    assign WriteMissCount = r_writeMissCount;
    assign WriteBackCount = r_writeBackCount;
    assign InvalCount     = r_invalCount;
`endif

endmodule

// File: tb/tb_msi_directory_controller.sv
// Directed, table-driven bench for msi_directory_controller; acts as the
// three caches' requester, owner-fetch responder and main memory.
module tb_msi_directory_controller;

    localparam logic [1:0] RM = 2'b00;
    localparam logic [1:0] WM = 2'b01;
    localparam logic [1:0] WB = 2'b10;

    logic       Clock = 1'b0;
    logic       ResetN = 1'b0;
    logic       ReqValid = 1'b0;
    logic       ReqReady;
    logic [1:0] ReqProcessor = '0;
    logic [1:0] ReqOp = '0;
    logic [3:0] ReqAddress = '0;
    logic [3:0] ReqData = '0;
    logic       InvalValid;
    logic [2:0] InvalMask;
    logic       FetchValid;
    logic [1:0] FetchProcessor;
    logic       FetchAck = 1'b0;
    logic [3:0] FetchData = '0;
    logic       MemReqValid;
    logic       MemWrite;
    logic [3:0] MemAddress;
    logic [3:0] MemWrData;
    logic       MemRdValid = 1'b0;
    logic [3:0] MemRdData = '0;
    logic       RespValid;
    logic [1:0] RespProcessor;
    logic [3:0] RespData;
    logic       RespError;
`ifdef DIR_STATS_EN
    logic [7:0] ReadMissCount;
    logic [7:0] WriteMissCount;
    logic [7:0] WriteBackCount;
    logic [7:0] InvalCount;
`endif

    int total = 0;
    int bad = 0;

    always #5 Clock = ~Clock;

    msi_directory_controller dut (
        .Clock          (Clock),
        .ResetN         (ResetN),
        .ReqValid       (ReqValid),
        .ReqReady       (ReqReady),
        .ReqProcessor   (ReqProcessor),
        .ReqOp          (ReqOp),
        .ReqAddress     (ReqAddress),
        .ReqData        (ReqData),
        .InvalValid     (InvalValid),
        .InvalMask      (InvalMask),
        .FetchValid     (FetchValid),
        .FetchProcessor (FetchProcessor),
        .FetchAck       (FetchAck),
        .FetchData      (FetchData),
        .MemReqValid    (MemReqValid),
        .MemWrite       (MemWrite),
        .MemAddress     (MemAddress),
        .MemWrData      (MemWrData),
        .MemRdValid     (MemRdValid),
        .MemRdData      (MemRdData),
        .RespValid      (RespValid),
        .RespProcessor  (RespProcessor),
        .RespData       (RespData),
        .RespError      (RespError)
`ifdef DIR_STATS_EN
        ,
        .ReadMissCount  (ReadMissCount),
        .WriteMissCount (WriteMissCount),
        .WriteBackCount (WriteBackCount),
        .InvalCount     (InvalCount)
`endif
    );

    typedef struct {
        logic [1:0] proc;
        logic [1:0] op;
        logic [3:0] addr;
        logic [3:0] wdata;
        int         memWait;
        logic [3:0] memData;
        logic [3:0] fetchData;
        logic [2:0] expInval;
        bit         expFetch;
        logic [1:0] expFetchProc;
        bit         expMemRd;
        bit         expMemWr;
        logic [3:0] expMemWrData;
        logic [3:0] expResp;
        bit         expErr;
        int         expLat;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic [1:0] proc, input logic [1:0] op, input logic [3:0] addr,
                                input logic [3:0] wdata, input int memWait, input logic [3:0] memData,
                                input logic [3:0] fetchData, input logic [2:0] expInval, input bit expFetch,
                                input logic [1:0] expFetchProc, input bit expMemRd, input bit expMemWr,
                                input logic [3:0] expMemWrData, input logic [3:0] expResp, input bit expErr,
                                input int expLat);
        vec_t v;
        v.proc = proc; v.op = op; v.addr = addr; v.wdata = wdata;
        v.memWait = memWait; v.memData = memData; v.fetchData = fetchData;
        v.expInval = expInval; v.expFetch = expFetch; v.expFetchProc = expFetchProc;
        v.expMemRd = expMemRd; v.expMemWr = expMemWr; v.expMemWrData = expMemWrData;
        v.expResp = expResp; v.expErr = expErr; v.expLat = expLat;
        return v;
    endfunction

    function automatic vec_t mkErr(input logic [1:0] proc, input logic [1:0] op, input logic [3:0] addr,
                                   input logic [3:0] wdata);
        return mk(proc, op, addr, wdata, 0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 2);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full transaction: issue, act as owner/memory, then compare what was seen.
    task automatic applyStimulus(input vec_t v, input string tag);
        int cyc, rdAt, fetchAt, waitCnt, lat;
        int invalCnt, fetchCnt, memRdCnt, memWrCnt;
        bit done, busyReady, respErr;
        logic [2:0] invalMask;
        logic [1:0] fetchProc, respProc;
        logic [3:0] memRdAddr, memWrAddr, memWrData, respData;
        invalCnt = 0; fetchCnt = 0; memRdCnt = 0; memWrCnt = 0; lat = 0;
        rdAt = -1; fetchAt = -1; done = 1'b0; respErr = 1'b0;
        invalMask = '0; fetchProc = '0; respProc = '0;
        memRdAddr = '0; memWrAddr = '0; memWrData = '0; respData = '0;
        waitCnt = 0;
        while (!ReqReady && waitCnt < 20) begin
            @(posedge Clock); #1;
            waitCnt++;
        end
        checkOutput({tag, ".ready"}, int'(ReqReady), 1);
        ReqValid = 1'b1; ReqProcessor = v.proc; ReqOp = v.op; ReqAddress = v.addr; ReqData = v.wdata;
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        busyReady = ReqReady;
        cyc = 0;
        while (!done && cyc < 40) begin
            if (InvalValid) begin invalCnt++; invalMask = InvalMask; end
            if (FetchValid) begin fetchCnt++; fetchProc = FetchProcessor; fetchAt = cyc + 1; end
            if (MemReqValid && !MemWrite) begin memRdCnt++; memRdAddr = MemAddress; rdAt = cyc + v.memWait; end
            if (MemReqValid && MemWrite) begin memWrCnt++; memWrAddr = MemAddress; memWrData = MemWrData; end
            if (RespValid) begin
                done = 1'b1; lat = cyc + 1;
                respData = RespData; respErr = RespError; respProc = RespProcessor;
            end
            MemRdValid = (cyc == rdAt);
            MemRdData  = v.memData;
            FetchAck   = (cyc == fetchAt);
            FetchData  = v.fetchData;
            if (!done) begin
                @(posedge Clock); #1;
                cyc++;
            end
        end
        MemRdValid = 1'b0;
        FetchAck = 1'b0;
        checkOutput({tag, ".respSeen"}, int'(done), 1);
        checkOutput({tag, ".busyReady"}, int'(busyReady), 0);
        checkOutput({tag, ".latency"}, lat, v.expLat);
        checkOutput({tag, ".respError"}, int'(respErr), int'(v.expErr));
        checkOutput({tag, ".respProc"}, int'(respProc), int'(v.proc));
        checkOutput({tag, ".invalCount"}, invalCnt, (v.expInval != '0) ? 1 : 0);
        if (v.expInval != '0) checkOutput({tag, ".invalMask"}, int'(invalMask), int'(v.expInval));
        checkOutput({tag, ".fetchCount"}, fetchCnt, int'(v.expFetch));
        if (v.expFetch) checkOutput({tag, ".fetchProc"}, int'(fetchProc), int'(v.expFetchProc));
        checkOutput({tag, ".memRdCount"}, memRdCnt, int'(v.expMemRd));
        if (v.expMemRd) checkOutput({tag, ".memRdAddr"}, int'(memRdAddr), int'(v.addr));
        checkOutput({tag, ".memWrCount"}, memWrCnt, int'(v.expMemWr));
        if (v.expMemWr) begin
            checkOutput({tag, ".memWrAddr"}, int'(memWrAddr), int'(v.addr));
            checkOutput({tag, ".memWrData"}, int'(memWrData), int'(v.expMemWrData));
        end
        if (!v.expErr) checkOutput({tag, ".respData"}, int'(respData), int'(v.expResp));
    endtask

    initial begin
        int seen, waitCnt, respCnt;

        vecs[0]  = mk(0, RM, 1, 0, 2, 4'b0010, 0, 3'b000, 0, 0, 1, 0, 0, 4'b0010, 0, 5);
        vecs[1]  = mk(1, WM, 1, 0, 2, 4'b0101, 0, 3'b001, 0, 0, 1, 0, 0, 4'b0101, 0, 6);
        vecs[2]  = mk(2, RM, 1, 0, 0, 0, 4'b0111, 3'b000, 1, 1, 0, 1, 4'b0111, 4'b0111, 0, 5);
        vecs[3]  = mkErr(0, WB, 4'd3, 4'b0100);
        vecs[4]  = mkErr(0, RM, 4'd0, 4'b0000);
        vecs[5]  = mkErr(1, RM, 4'd9, 4'b0000);
        vecs[6]  = mkErr(0, 2'b11, 4'd2, 4'b0000);
        vecs[7]  = mkErr(3, RM, 4'd2, 4'b0000);
        vecs[8]  = mk(2, WM, 1, 0, 1, 4'b1001, 0, 3'b010, 0, 0, 1, 0, 0, 4'b1001, 0, 5);
        vecs[9]  = mkErr(2, RM, 4'd1, 4'b0000);
        vecs[10] = mk(2, WB, 1, 4'b1100, 0, 0, 0, 3'b000, 0, 0, 0, 1, 4'b1100, 4'b1100, 0, 3);
        vecs[11] = mkErr(1, WB, 4'd1, 4'b0110);
        vecs[12] = mk(0, WM, 2, 0, 1, 4'b0011, 0, 3'b000, 0, 0, 1, 0, 0, 4'b0011, 0, 4);
        vecs[13] = mk(1, WM, 2, 0, 0, 0, 4'b1110, 3'b001, 1, 0, 0, 0, 0, 4'b1110, 0, 5);
        vecs[14] = mk(0, RM, 8, 0, 3, 4'b1111, 0, 3'b000, 0, 0, 1, 0, 0, 4'b1111, 0, 6);
        vecs[15] = mk(1, RM, 8, 0, 1, 4'b1000, 0, 3'b000, 0, 0, 1, 0, 0, 4'b1000, 0, 4);
        vecs[16] = mk(2, WM, 8, 0, 1, 4'b0001, 0, 3'b011, 0, 0, 1, 0, 0, 4'b0001, 0, 5);
        vecs[17] = mk(0, RM, 5, 0, 1, 4'b0110, 0, 3'b000, 0, 0, 1, 0, 0, 4'b0110, 0, 4);
        vecs[18] = mk(0, WM, 5, 0, 1, 4'b1101, 0, 3'b000, 0, 0, 1, 0, 0, 4'b1101, 0, 4);
        vecs[19] = mk(0, WM, 7, 0, 1, 4'b1011, 0, 3'b000, 0, 0, 1, 0, 0, 4'b1011, 0, 4);

        #1;
        checkOutput("rst.ReqReady", int'(ReqReady), 0);
        checkOutput("rst.RespValid", int'(RespValid), 0);
        checkOutput("rst.MemReqValid", int'(MemReqValid), 0);
        checkOutput("rst.InvalValid", int'(InvalValid), 0);
        checkOutput("rst.FetchValid", int'(FetchValid), 0);
        repeat (2) @(posedge Clock);
        #1 ResetN = 1'b1;
        @(posedge Clock); #1;
        checkOutput("rst.ReadyAfterRelease", int'(ReqReady), 1);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i], $sformatf("v%0d", i));
        end

        // Stray memory/fetch responses while idle must not start anything.
        @(posedge Clock); #1;
        seen = 0;
        MemRdValid = 1'b1; FetchAck = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge Clock); #1;
            if (RespValid || MemReqValid || FetchValid || InvalValid) seen++;
        end
        MemRdValid = 1'b0; FetchAck = 1'b0;
        checkOutput("stray.activity", seen, 0);
        checkOutput("stray.ready", int'(ReqReady), 1);

        // Reset in the middle of a memory read; the late data must be dropped.
        ReqValid = 1'b1; ReqProcessor = 2'd0; ReqOp = RM; ReqAddress = 4'd6; ReqData = 4'd0;
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        waitCnt = 0;
        while (!MemReqValid && waitCnt < 10) begin
            @(posedge Clock); #1;
            waitCnt++;
        end
        checkOutput("midrst.memReqSeen", int'(MemReqValid), 1);
        checkOutput("midrst.busyReady", int'(ReqReady), 0);
        ResetN = 1'b0;
        #1;
        checkOutput("midrst.MemReqValid", int'(MemReqValid), 0);
        checkOutput("midrst.ReqReady", int'(ReqReady), 0);
        @(posedge Clock); #1;
        ResetN = 1'b1;
        respCnt = 0;
        MemRdValid = 1'b1; MemRdData = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            @(posedge Clock); #1;
            if (k == 2) MemRdValid = 1'b0;
            if (RespValid) respCnt++;
        end
        checkOutput("midrst.lateResp", respCnt, 0);
        checkOutput("midrst.ready", int'(ReqReady), 1);
        // Block 7 was M owned by P0 before the reset, so only a cleared table rejects this.
        applyStimulus(mkErr(0, WB, 4'd7, 4'b0001), "midrst.wbAfterClear");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
